// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Contents: the fetch FSM state enum and the default reset fetch address.
package instr_fetch_pkg;

  // Fetch control states
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } fetch_state_t;

  // Default first fetch address after reset
  localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_buf.sv
// Small flush-able FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   flush            drop every stored entry (wins over push/pop)
//   push, din        write one entry
//   pop              consumer takes the head entry (ignored when empty)
//   dout, valid      head entry and non-empty flag (both from registers)
//   count            current occupancy
// Entries are kept in a shift array with the head always at index 0, so
// the depth-1 case needs no pointer logic.
module fetch_buf
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [DATA_W-1:0]            din,
  input  logic                         pop,
  output logic [DATA_W-1:0]            dout,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem   [DEPTH];
  logic [DATA_W-1:0] mem_n [DEPTH];
  logic [CNT_W-1:0]  count_n;
  logic              pop_ok;
  logic              push_ok;

  // A full buffer still accepts a push when the head leaves this cycle
  assign pop_ok  = pop && valid;
  assign push_ok = push && ((count < CNT_W'(DEPTH)) || pop_ok);
  assign dout    = mem[0];

  // Next contents: shift on pop, then append behind the remaining entries
  always_comb begin
    count_n = count;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_n[i] = mem[i];
    end
    if (flush) begin
      count_n = '0;
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          mem_n[i] = mem[i + 1];
        end
        count_n = count_n - CNT_W'(1);
      end
      if (push_ok) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (CNT_W'(i) == count_n) begin
            mem_n[i] = din;
          end
        end
        count_n = count_n + CNT_W'(1);
      end
    end
  end

  // Storage, occupancy and registered valid flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      valid <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      count <= count_n;
      valid <= (count_n != '0);
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= mem_n[i];
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives a synchronous instruction memory (one
// cycle read latency), buffers returned words tagged with their address
// and offers them to decode with a valid/ready handshake.
// Build option: define INSTR_FETCH_SKID_EN for a 2-entry buffer that
// sustains one word per cycle; otherwise a 1-entry buffer gives one word
// every two cycles.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   halt                suppress new fetches (buffered words still drain)
//   redirect, target    taken branch/jump and its destination
//   pc                  fetch address to the memory (target during redirect)
//   mem_instr           memory read data, one cycle after pc is sampled
//   instr_valid/ready   decode handshake
//   instr, instr_pc     delivered word and its address
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PC_WIDTH = 4,
  parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc,
  input  logic [WIDTH-1:0]    mem_instr,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [WIDTH-1:0]    instr,
  output logic [PC_WIDTH-1:0] instr_pc
);

`ifdef INSTR_FETCH_SKID_EN
  localparam int unsigned BUF_DEPTH = 2;
`else
  localparam int unsigned BUF_DEPTH = 1;
`endif
  localparam int unsigned CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = PC_WIDTH + WIDTH;

  fetch_state_t          state;
  logic [PC_WIDTH-1:0]   pc_q;
  logic                  inflight;
  logic [PC_WIDTH-1:0]   inflight_pc;
  logic [CNT_W-1:0]      buf_count;
  logic [ENTRY_W-1:0]    buf_dout;
  logic                  take_c;
  logic [OCC_W-1:0]      occ_c;
  logic                  issue_c;
  logic                  push_c;

  // Occupancy once this cycle's handshake and returning word settle;
  // counting the pop is what lets the skid build keep one word per cycle
  assign take_c  = instr_valid && instr_ready;
  assign occ_c   = OCC_W'(buf_count) - OCC_W'(take_c) + OCC_W'(inflight);
  assign issue_c = (state == RUN) && !halt && (occ_c < OCC_W'(BUF_DEPTH));

  // The redirect target must reach the memory in the redirect cycle itself
  assign pc = (redirect && !reset) ? target : pc_q;

  // Returning word is squashed when a redirect lands in the same cycle
  assign push_c = inflight && !redirect;

  assign {instr_pc, instr} = buf_dout;

  // Fetch FSM, fetch address and in-flight tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc_q        <= PC_WIDTH'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      state       <= RUN;
      pc_q        <= target + PC_WIDTH'(1);
      inflight    <= 1'b1;
      inflight_pc <= target;
    end else begin
      inflight <= issue_c;
      if (issue_c) begin
        inflight_pc <= pc_q;
        pc_q        <= pc_q + PC_WIDTH'(1);
      end
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (halt) state <= STALL;
        STALL:   if (!halt) state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

  fetch_buf #(
    .DATA_W (ENTRY_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push_c),
    .din   ({inflight_pc, mem_instr}),
    .pop   (instr_ready),
    .dout  (buf_dout),
    .valid (instr_valid),
    .count (buf_count)
  );

endmodule
